// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider and its step logic.
package divider_pkg;

    // Controller states, held in a 2-bit register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Divisor/remainder width used when the parent does not override N.
    localparam int DEFAULT_N = 8;

    // Fill bit replicated across the quotient when the divisor is zero.
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, then try to
// subtract the divisor and report whether the subtraction was kept.
module div_step
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0]   rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N:0]   rem_o,
    output logic         qbit_o
);

    logic [N+1:0] shifted;
    logic [N+1:0] divisorExt;

    // Compare the shifted remainder with the divisor and restore on underflow.
    always_comb begin
        shifted    = {rem_i, bit_i};
        divisorExt = {2'b00, divisor_i};
        qbit_o     = (shifted >= divisorExt);
        rem_o      = qbit_o ? (N+1)'(shifted - divisorExt) : shifted[N:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, with a one-edge shortcut for divide-by-zero.
module divider
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] Z,
    input  logic [N-1:0]   Y,
    output logic [2*N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           div_zero
);

    localparam int CW = $clog2(2*N);

    state_t         state_q;
    state_t         state_d;

    logic [2*N-1:0] dividend_q;
    logic [N-1:0]   divisor_q;
    logic [N:0]     rem_q;
    logic [CW-1:0]  count_q;
    logic [2*N-1:0] quot_q;
    logic [N-1:0]   rmd_q;
    logic           divZero_q;

    logic [N:0]     stepRem;
    logic           stepQBit;

    // The dividend register doubles as the quotient shift register: its MSB
    // feeds the step and the new quotient bit enters at its LSB.
    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[2*N-1]),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .qbit_o    (stepQBit)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only matters while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (Y != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand capture, iterative datapath and held result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            quot_q     <= '0;
            rmd_q      <= '0;
            divZero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (Y != '0) begin
                            dividend_q <= Z;
                            divisor_q  <= Y;
                            rem_q      <= '0;
                            count_q    <= CW'(2*N-1);
                            divZero_q  <= 1'b0;
                        end else begin
                            quot_q    <= {(2*N){DIV_ZERO_Q_BIT}};
                            rmd_q     <= Z[N-1:0];
                            divZero_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_q      <= stepRem;
                    dividend_q <= {dividend_q[2*N-2:0], stepQBit};
                    count_q    <= count_q - CW'(1);
                    if (count_q == '0) begin
                        quot_q <= {dividend_q[2*N-2:0], stepQBit};
                        rmd_q  <= stepRem[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q        = quot_q;
    assign R        = rmd_q;
    assign div_zero = divZero_q;

endmodule
